axi_id_remap: RTL
=================

Name: axi_id_remap

Overview:
- Parametrised AXI ID-width adapter for one request/response channel pair: AR/R, or AW/B with the response last tied high.
- Compresses wide master IDs (PS GP port, 12 bits) into a small pool of narrow IDs for the memory-side port (HP/MIG slave, 6 bits or fewer).
- Restores the original ID on responses.
- Preserves per-ID ordering: every outstanding transaction with the same wide ID maps to the same narrow ID.
- Instantiated twice between the PS/Top AXI ports and the memory interconnect.

Parameters:
- S_ID_W, 12, upstream (wide) ID width.
- M_ID_W, 4, downstream (narrow) ID width.
- NUM_SLOTS, 8, number of remap table entries; must be ≤ 2**M_ID_W and ≥ 1.
- CNT_W, 4, per-slot outstanding-transaction counter width; max outstanding per slot is 2**CNT_W-1.
- REQ_W, 64, request payload width (addr/len/size/burst/etc.), passed through untouched.
- RSP_W, 66, response payload width (data/resp), passed through untouched.

Ports:
- clock  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- s_req_valid  in  1  upstream request valid.
- s_req_ready  out  1  upstream request ready.
- s_req_id  in  S_ID_W  upstream request ID.
- s_req_payload  in  REQ_W  request payload.
- m_req_valid  out  1  downstream request valid.
- m_req_ready  in  1  downstream request ready.
- m_req_id  out  M_ID_W  narrow ID, equal to the slot index.
- m_req_payload  out  REQ_W  equals s_req_payload.
- m_rsp_valid  in  1  downstream response valid.
- m_rsp_ready  out  1  downstream response ready.
- m_rsp_id  in  M_ID_W  narrow response ID.
- m_rsp_last  in  1  final beat of the transaction; tie 1 for B.
- m_rsp_payload  in  RSP_W  response payload.
- s_rsp_valid  out  1  upstream response valid.
- s_rsp_ready  in  1  upstream response ready.
- s_rsp_id  out  S_ID_W  restored wide ID.
- s_rsp_last  out  1  equals m_rsp_last.
- s_rsp_payload  out  RSP_W  equals m_rsp_payload.
- busy  out  1  high when any slot is allocated.
- remap_err  out  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Slot table: per slot a registered `alloc` bit, `orig_id[S_ID_W]` and `cnt[CNT_W]`. On reset, all alloc=0, cnt=0, orig_id=0, and remap_err=0.
- Request path is zero-latency combinational and uses registered table state only:
  - `hit` = some allocated slot has orig_id == s_req_id. At most one can match (invariant).
  - `sel` = the hit slot if hit; otherwise the lowest-index free slot.
  - `accept` = (hit && cnt[sel] != all-ones) || (!hit && a free slot exists).
  - m_req_valid = s_req_valid && accept.
  - s_req_ready = m_req_ready && accept.
  - m_req_id = sel, zero-extended to M_ID_W.
  - m_req_valid never depends on m_req_ready.
- On request handshake (m_req_valid && m_req_ready):
  - If !hit, set alloc[sel]=1 and orig_id[sel]=s_req_id.
  - cnt[sel] increments.
- Response path is zero-latency pass-through:
  - s_rsp_valid = m_rsp_valid; m_rsp_ready = s_rsp_ready.
  - s_rsp_id = orig_id[m_rsp_id]. An m_rsp_id ≥ NUM_SLOTS yields 0.
- On response handshake with m_rsp_last=1 for slot k: cnt[k] decrements. When cnt reaches 0, alloc[k] clears the same edge.
- Non-last beats do not change the table.
- Simultaneous request and last-response on the same slot: cnt is unchanged and the slot stays allocated; orig_id is unchanged.
- Slot freeing this cycle is not visible to allocation until the next cycle. There is no same-cycle reuse, and a full table stalls for one extra cycle.
- Counter saturated at 2**CNT_W-1: the request stalls even if a decrement occurs this cycle, and is accepted the following cycle.
- A last-response to an unallocated slot, or to an index ≥ NUM_SLOTS, is passed through. cnt does not underflow and the table is unchanged.
- busy = OR of all alloc bits (registered-state derived).
- Reset asserted mid-operation clears the table immediately. In-flight transactions are lost; system reset covers both ports.

Optional Feature:
- Macro: AXI_ID_REMAP_ERR_CHECK_EN.
- Defined: remap_err sets (sticky until reset) on a last-response handshake whose m_rsp_id is unallocated or ≥ NUM_SLOTS, and on any request handshake while cnt[sel] is saturated (assertion of the internal invariant).
- Undefined: remap_err is tied 0 and no checking logic is built.

Test Plan:
- Reset, then one request with id 0x0A5 → m_req_id=0, busy=1. Response id 0, last=1 → s_rsp_id=0x0A5, busy=0 next cycle.
- Requests with ids 0x001, 0x002, 0x001 → m_req_ids 0, 1, 0; cnt[0]=2. Two last responses for id 0 are needed before slot 0 frees.
- NUM_SLOTS=8: issue 8 distinct ids, then a 9th → s_req_ready=0. A last response frees slot 3 → the 9th is accepted one cycle later with m_req_id=3.
- CNT_W=2: issue 3 requests with the same id, then a 4th → stalled. Issue a last-response and the 4th together → the 4th is accepted the next cycle, cnt=3.
- Burst of 4 beats on id 2 with last only on beat 4 → slot 2 stays allocated through beats 1–3 and frees after beat 4. s_rsp_ready low mid-burst → m_rsp_ready low and the table is held.
- With AXI_ID_REMAP_ERR_CHECK_EN: a last-response on a free slot 5 → remap_err=1 and it stays 1; reset_n low → remap_err=0 and busy=0 asynchronously.

Source files
------------

// File: rtl/axi_id_remap.sv
// AXI ID-width adapter: folds wide upstream IDs onto a small pool of narrow slot IDs and restores them on responses.
// Optional sticky protocol checking is built only when AXI_ID_REMAP_ERR_CHECK_EN is defined.
module axi_id_remap #(
    parameter int unsigned S_ID_W    = 12,
    parameter int unsigned M_ID_W    = 4,
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned REQ_W     = 64,
    parameter int unsigned RSP_W     = 66
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              s_req_valid,
    output logic              s_req_ready,
    input  logic [S_ID_W-1:0] s_req_id,
    input  logic [REQ_W-1:0]  s_req_payload,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [M_ID_W-1:0] m_req_id,
    output logic [REQ_W-1:0]  m_req_payload,
    input  logic              m_rsp_valid,
    output logic              m_rsp_ready,
    input  logic [M_ID_W-1:0] m_rsp_id,
    input  logic              m_rsp_last,
    input  logic [RSP_W-1:0]  m_rsp_payload,
    output logic              s_rsp_valid,
    input  logic              s_rsp_ready,
    output logic [S_ID_W-1:0] s_rsp_id,
    output logic              s_rsp_last,
    output logic [RSP_W-1:0]  s_rsp_payload,
    output logic              busy,
    output logic              remap_err
);

    logic [NUM_SLOTS-1:0] alloc_q, alloc_d;
    logic [S_ID_W-1:0]    orig_id_q [NUM_SLOTS];
    logic [S_ID_W-1:0]    orig_id_d [NUM_SLOTS];
    logic [CNT_W-1:0]     cnt_q [NUM_SLOTS];
    logic [CNT_W-1:0]     cnt_d [NUM_SLOTS];

    logic              hit, hit_sat, free_found, accept;
    logic [M_ID_W-1:0] hit_idx, free_idx, sel;
    logic              rsp_alloc;
    logic [S_ID_W-1:0] rsp_orig;
    logic              req_fire, rsp_fire_last;

    // Lookup uses registered table state only, so a slot freed this cycle is not reusable until the next.
    always_comb begin
        hit        = 1'b0;
        hit_sat    = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (alloc_q[k] && (orig_id_q[k] == s_req_id)) begin
                hit     = 1'b1;
                hit_idx = M_ID_W'(k);
                hit_sat = (cnt_q[k] == '1);
            end
            if (!alloc_q[k] && !free_found) begin
                free_found = 1'b1;
                free_idx   = M_ID_W'(k);
            end
        end
        sel    = hit ? hit_idx : free_idx;
        accept = hit ? !hit_sat : free_found;
    end

    assign m_req_valid   = s_req_valid && accept;
    assign s_req_ready   = m_req_ready && accept;
    assign m_req_id      = sel;
    assign m_req_payload = s_req_payload;

    // Out-of-range response IDs match no slot and therefore restore as zero.
    always_comb begin
        rsp_alloc = 1'b0;
        rsp_orig  = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (M_ID_W'(k) == m_rsp_id) begin
                rsp_alloc = alloc_q[k];
                rsp_orig  = orig_id_q[k];
            end
        end
    end

    assign s_rsp_valid   = m_rsp_valid;
    assign m_rsp_ready   = s_rsp_ready;
    assign s_rsp_id      = rsp_orig;
    assign s_rsp_last    = m_rsp_last;
    assign s_rsp_payload = m_rsp_payload;
    assign busy          = |alloc_q;

    assign req_fire      = m_req_valid && m_req_ready;
    assign rsp_fire_last = m_rsp_valid && s_rsp_ready && m_rsp_last;

    always_comb begin
        alloc_d = alloc_q;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            logic inc, dec;
            orig_id_d[k] = orig_id_q[k];
            cnt_d[k]     = cnt_q[k];
            inc = req_fire && (sel == M_ID_W'(k));
            dec = rsp_fire_last && (m_rsp_id == M_ID_W'(k)) && alloc_q[k] && (cnt_q[k] != '0);
            if (inc && !dec) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
                if (cnt_q[k] == CNT_W'(1)) begin
                    alloc_d[k] = 1'b0;
                end
            end
            if (inc && !alloc_q[k]) begin
                alloc_d[k]   = 1'b1;
                orig_id_d[k] = s_req_id;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alloc_q <= '0;
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                orig_id_q[k] <= '0;
                cnt_q[k]     <= '0;
            end
        end else begin
            alloc_q <= alloc_d;
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                orig_id_q[k] <= orig_id_d[k];
                cnt_q[k]     <= cnt_d[k];
            end
        end
    end

`ifdef AXI_ID_REMAP_ERR_CHECK_EN
    logic remap_err_q, remap_err_d;

    always_comb begin
        remap_err_d = remap_err_q
                    | (rsp_fire_last && !rsp_alloc)
                    | (req_fire && hit && hit_sat);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remap_err_q <= 1'b0;
        end else begin
            remap_err_q <= remap_err_d;
        end
    end

    assign remap_err = remap_err_q;
`else
    assign remap_err = 1'b0;
`endif

endmodule
